// File: rtl/mem_responder_pkg.sv
// Shared types and constants for mem_responder: request/response buses,
// RAM port bundles and FSM state encoding.
package mem_responder_wires;

    localparam int unsigned XLEN = 32;

    // FSM state encoding
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    typedef struct packed {
        logic            mem_valid;
        logic            mem_fence;
        logic            mem_instr;
        logic [XLEN-1:0] mem_addr;
        logic [XLEN-1:0] mem_wdata;
        logic [3:0]      mem_wstrb;
    } mem_in_type;

    typedef struct packed {
        logic            mem_ready;
        logic [XLEN-1:0] mem_rdata;
    } mem_out_type;

    typedef struct packed {
        logic [3:0]      wen;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } mem_responder_ram_in_type;

    typedef struct packed {
        logic [XLEN-1:0] rdata;
    } mem_responder_ram_out_type;

endpackage

// File: rtl/mem_responder_ram.sv
// Word array for mem_responder: byte-enabled write, registered read.
// addr is a word index; only the low mem_depth bits select a word.
module mem_responder_ram
    import mem_responder_wires::*;
#(
    parameter int mem_depth = 10
) (
    input  logic                      clk,
    input  mem_responder_ram_in_type  ram_in,
    output mem_responder_ram_out_type ram_out
);

    localparam int unsigned WORDS = 2 ** mem_depth;

    logic [XLEN-1:0]      mem_q [WORDS];
    logic [XLEN-1:0]      rdata_q;
    logic [mem_depth-1:0] idx;
    logic                 unused_ok;

    assign idx       = ram_in.addr[mem_depth-1:0];
    assign unused_ok = ^ram_in.addr;

    // Byte-lane writes and read-first registered read
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (ram_in.wen[b]) begin
                mem_q[idx][8*b +: 8] <= ram_in.wdata[8*b +: 8];
            end
        end
        rdata_q <= mem_q[idx];
    end

    assign ram_out.rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the mem_in_type/mem_out_type protocol with a
// fixed access latency of mem_wait extra cycles.
// Optional feature: define MEM_RANGE_CHECK_EN to answer out-of-window
// accesses with zero data and suppress their writes.
module mem_responder
    import mem_responder_wires::*;
#(
    parameter int          mem_depth     = 10,
    parameter int          mem_wait      = 1,
    parameter logic [31:0] mem_base_addr = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  mem_in_type  mem_in,
    output mem_out_type mem_out
);

    localparam int unsigned BYTE_AW  = mem_depth + 2;
    localparam logic [3:0]  CNT_INIT = 4'(mem_wait - 1);

    logic [1:0]      state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [3:0]      wstrb_q, wstrb_d;
    logic            fence_q, fence_d;
    logic [XLEN-1:0] rsp_idx_q, rsp_idx_d;
    logic            ready_q;
    logic            zero_q;

    logic            fire;
    logic            use_in;
    logic [XLEN-1:0] acc_addr;
    logic [XLEN-1:0] acc_wdata;
    logic [3:0]      acc_wstrb;
    logic            acc_fence;
    logic [XLEN-1:0] acc_off;
    logic            acc_in_range;
    logic            rsp_zero;
    logic            unused_ok;

    mem_responder_ram_in_type  ram_in;
    mem_responder_ram_out_type ram_out;

    // Next-state: accept in IDLE/RESP, count down in WAIT, fire into RESP
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        fence_d = fence_q;
        fire    = 1'b0;
        use_in  = 1'b0;
        case (state_q)
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    fire    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                if (mem_in.mem_valid) begin
                    addr_d  = mem_in.mem_addr;
                    wdata_d = mem_in.mem_wdata;
                    wstrb_d = mem_in.mem_wstrb;
                    fence_d = mem_in.mem_fence;
                    if (mem_wait == 0) begin
                        state_d = RESP;
                        fire    = 1'b1;
                        use_in  = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // Access decode: zero-latency requests bypass the request latch
    always_comb begin
        acc_addr  = use_in ? mem_in.mem_addr  : addr_q;
        acc_wdata = use_in ? mem_in.mem_wdata : wdata_q;
        acc_wstrb = use_in ? mem_in.mem_wstrb : wstrb_q;
        acc_fence = use_in ? mem_in.mem_fence : fence_q;
        acc_off   = acc_addr - mem_base_addr;
`ifdef MEM_RANGE_CHECK_EN
        acc_in_range = (acc_off >> BYTE_AW) == 32'd0;
`else
        acc_in_range = 1'b1;
`endif
        rsp_zero  = acc_fence | (acc_wstrb != 4'd0) | ~acc_in_range;
        // Keep the RAM pointed at the last responded word so rdata holds
        rsp_idx_d = fire ? {2'b00, acc_off[XLEN-1:2]} : rsp_idx_q;

        ram_in.addr  = rsp_idx_d;
        ram_in.wdata = acc_wdata;
        ram_in.wen   = (fire && !acc_fence && acc_in_range) ? acc_wstrb : 4'd0;
    end

    assign unused_ok = ^{mem_in.mem_instr, acc_off[1:0], BYTE_AW};

    mem_responder_ram #(
        .mem_depth(mem_depth)
    ) u_ram (
        .clk    (clk),
        .ram_in (ram_in),
        .ram_out(ram_out)
    );

    // State, counter, latched request and response flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= 4'd0;
            fence_q   <= 1'b0;
            rsp_idx_q <= '0;
            ready_q   <= 1'b0;
            zero_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            fence_q   <= fence_d;
            rsp_idx_q <= rsp_idx_d;
            ready_q   <= fire;
            if (fire) begin
                zero_q <= rsp_zero;
            end
        end
    end

    assign mem_out.mem_ready = ready_q;
    assign mem_out.mem_rdata = zero_q ? '0 : ram_out.rdata;

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder. Five instances cover the
// different latency/window configurations; expectations for the out-of-range
// case follow MEM_RANGE_CHECK_EN.
module tb_mem_responder;
    import mem_responder_wires::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    mem_in_type  req_a [5];
    mem_out_type rsp_a [5];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    mem_responder #(.mem_depth(10), .mem_wait(2), .mem_base_addr(32'h0)) u_w2 (
        .clk(clk), .rst(rst), .mem_in(req_a[0]), .mem_out(rsp_a[0]));
    mem_responder #(.mem_depth(10), .mem_wait(0), .mem_base_addr(32'h0)) u_w0 (
        .clk(clk), .rst(rst), .mem_in(req_a[1]), .mem_out(rsp_a[1]));
    mem_responder #(.mem_depth(10), .mem_wait(1), .mem_base_addr(32'h0)) u_w1 (
        .clk(clk), .rst(rst), .mem_in(req_a[2]), .mem_out(rsp_a[2]));
    mem_responder #(.mem_depth(10), .mem_wait(3), .mem_base_addr(32'h0)) u_w3 (
        .clk(clk), .rst(rst), .mem_in(req_a[3]), .mem_out(rsp_a[3]));
    mem_responder #(.mem_depth(4), .mem_wait(1), .mem_base_addr(32'h1000)) u_oor (
        .clk(clk), .rst(rst), .mem_in(req_a[4]), .mem_out(rsp_a[4]));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One request on instance k; checks latency, data, single-cycle ready, hold
    task automatic xact(input string tag, input int k, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb,
                        input logic fence, input logic [31:0] exp_rd, input int exp_lat);
        int          lat;
        logic [31:0] rd;
        @(negedge clk);
        req_a[k].mem_valid = 1'b1;
        req_a[k].mem_fence = fence;
        req_a[k].mem_instr = 1'b0;
        req_a[k].mem_addr  = addr;
        req_a[k].mem_wdata = wdata;
        req_a[k].mem_wstrb = strb;
        lat = 0;
        rd  = 32'h0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (rsp_a[k].mem_ready) begin
                lat = c;
                rd  = rsp_a[k].mem_rdata;
                break;
            end
        end
        req_a[k].mem_valid = 1'b0;
        check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, "_rdata"}, rd, exp_rd);
        @(negedge clk);
        check_eq({tag, "_pulse"}, 32'(rsp_a[k].mem_ready), 32'h0);
        check_eq({tag, "_hold"}, rsp_a[k].mem_rdata, exp_rd);
    endtask

    logic [31:0] burst_w [4];
    logic        seen;

    initial begin
        for (int k = 0; k < 5; k++) req_a[k] = '0;
        burst_w[0] = 32'hA0A0_0001;
        burst_w[1] = 32'hB1B1_0002;
        burst_w[2] = 32'hC2C2_0003;
        burst_w[3] = 32'hD3D3_0004;

        repeat (3) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            check_eq("rst_ready", 32'(rsp_a[k].mem_ready), 32'h0);
            check_eq("rst_rdata", rsp_a[k].mem_rdata, 32'h0);
        end
        rst = 1'b0;

        // Read latency with mem_wait=2
        xact("pre10", 0, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0, 3);
        xact("rd10",  0, 32'h10, 32'h0,        4'h0, 1'b0, 32'hDEADBEEF, 3);

        // Byte-strobed write
        xact("pre20", 0, 32'h20, 32'h11223344, 4'hF, 1'b0, 32'h0, 3);
        xact("wr20",  0, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b0, 32'h0, 3);
        xact("rd20",  0, 32'h22, 32'h0,        4'h0, 1'b0, 32'h11BB33DD, 3);

        // Zero-latency burst with valid held high
        for (int i = 0; i < 4; i++)
            xact("preb", 1, 32'(4 * i), burst_w[i], 4'hF, 1'b0, 32'h0, 1);
        @(negedge clk);
        req_a[1].mem_valid = 1'b1;
        req_a[1].mem_wstrb = 4'h0;
        req_a[1].mem_addr  = 32'h0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("burst_ready", 32'(rsp_a[1].mem_ready), 32'h1);
            check_eq("burst_rdata", rsp_a[1].mem_rdata, burst_w[i]);
            if (i < 3) req_a[1].mem_addr = req_a[1].mem_addr + 32'd4;
            else       req_a[1].mem_valid = 1'b0;
        end
        @(negedge clk);
        check_eq("burst_end", 32'(rsp_a[1].mem_ready), 32'h0);

        // Fence with mem_wait=1: zero data, no array access
        xact("pre30", 2, 32'h30, 32'hCAFEF00D, 4'hF, 1'b0, 32'h0, 2);
        xact("rd30",  2, 32'h30, 32'h0,        4'h0, 1'b0, 32'hCAFEF00D, 2);
        xact("fence", 2, 32'h30, 32'h0BAD0BAD, 4'hF, 1'b1, 32'h0, 2);
        xact("rb30",  2, 32'h30, 32'h0,        4'h0, 1'b0, 32'hCAFEF00D, 2);

        // Address window, depth 4 at base 0x1000
        xact("pre1000", 4, 32'h1000, 32'h0BADF00D, 4'hF, 1'b0, 32'h0, 2);
        xact("rd1003",  4, 32'h1003, 32'h0,        4'h0, 1'b0, 32'h0BADF00D, 2);
`ifdef MEM_RANGE_CHECK_EN
        xact("rd1040",  4, 32'h1040, 32'h0,        4'h0, 1'b0, 32'h0, 2);
        xact("rd0ffc",  4, 32'h0FFC, 32'h0,        4'h0, 1'b0, 32'h0, 2);
        xact("wr1040",  4, 32'h1040, 32'hFFFFFFFF, 4'hF, 1'b0, 32'h0, 2);
        xact("rb1000",  4, 32'h1000, 32'h0,        4'h0, 1'b0, 32'h0BADF00D, 2);
`else
        xact("rd1040",  4, 32'h1040, 32'h0,        4'h0, 1'b0, 32'h0BADF00D, 2);
        xact("wr1040",  4, 32'h1040, 32'hFFFFFFFF, 4'hF, 1'b0, 32'h0, 2);
        xact("rb1000",  4, 32'h1000, 32'h0,        4'h0, 1'b0, 32'hFFFFFFFF, 2);
`endif

        // Reset during WAIT drops a pending write
        xact("pre40", 3, 32'h40, 32'h55AA55AA, 4'hF, 1'b0, 32'h0, 4);
        xact("rd40",  3, 32'h40, 32'h0,        4'h0, 1'b0, 32'h55AA55AA, 4);
        @(negedge clk);
        req_a[3].mem_valid = 1'b1;
        req_a[3].mem_fence = 1'b0;
        req_a[3].mem_addr  = 32'h40;
        req_a[3].mem_wdata = 32'h12345678;
        req_a[3].mem_wstrb = 4'hF;
        @(negedge clk);
        rst = 1'b1;
        req_a[3].mem_valid = 1'b0;
        @(negedge clk);
        check_eq("rstmid_ready", 32'(rsp_a[3].mem_ready), 32'h0);
        check_eq("rstmid_rdata", rsp_a[3].mem_rdata, 32'h0);
        rst  = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            seen = seen | rsp_a[3].mem_ready;
        end
        check_eq("rstmid_no_ready", 32'(seen), 32'h0);
        xact("rb40", 3, 32'h40, 32'h0, 4'h0, 1'b0, 32'h55AA55AA, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the core's `mem_in_type`/`mem_out_type` request protocol. It sits behind the instruction cache/TIM controller's `imem_in`/`imem_out` port, or any other initiator on the same interface, and serves single-word reads and byte-strobed writes from an on-chip word array with a fixed, configurable access latency. `mem_ready` is registered, so the initiator may derive its next `mem_valid`/`mem_addr` combinationally from `mem_ready` without creating a loop.

## Interface
Parameters:
- `mem_depth`, default 10: log2 of the number of 32-bit words.
- `mem_wait`, default 1: extra wait cycles per access (0..15).
- `mem_base_addr`, default 32'h0: byte address of word 0.

Ports:
- `clk`  input  1: clock; all state updates on the rising edge.
- `rst`  input  1: synchronous, active-high reset.
- `mem_in`  input  `mem_in_type`: request fields `mem_valid`, `mem_fence`, `mem_instr`, `mem_addr`, `mem_wdata`, `mem_wstrb`.
- `mem_out`  output  `mem_out_type`: response fields `mem_ready`, `mem_rdata`.

## Operation
- States:
  - IDLE: no request pending.
  - WAIT: latency counter running.
  - RESP: `mem_ready`=1 for exactly this one cycle.
- Accept condition: in IDLE or RESP, `mem_valid`=1 latches `mem_addr`, `mem_wdata`, `mem_wstrb` and `mem_fence`.
  - `mem_wait`=0: next state is RESP.
  - Otherwise: next state is WAIT, with `cnt` = `mem_wait`-1.
- WAIT: `cnt` decrements each cycle. At `cnt`=0, the next state is RESP.
- RESP: inputs in this cycle are treated as a new request (the initiator updates them combinationally on `mem_ready`). If `mem_valid`=0, next state is IDLE.
- `mem_valid` is ignored in WAIT. The initiator holds the request stable until `mem_ready`.
- Array access happens on the edge that enters RESP:
  - Read (`mem_wstrb`=0): `mem_rdata` = array[word index].
  - Write (`mem_wstrb`≠0): byte lane i is written iff `mem_wstrb[i]`. `mem_rdata` = 0.
  - Fence: no array access. `mem_rdata` = 0.
- Word index is `(mem_addr - mem_base_addr)[mem_depth+1:2]`. `mem_addr[1:0]` is ignored.
- `mem_instr` is informational only and does not affect behaviour.
- `mem_rdata` holds its value outside RESP until the next response overwrites it.
- Reset mid-operation drops any pending request. No write is performed and no `mem_ready` is issued for it.

## Timing
- Reset values: `mem_ready`=0, `mem_rdata`=0, state=IDLE, `cnt`=0.
- Array contents are not reset. They are zero at elaboration.
- Request sampled at edge T, so `mem_ready`=1 in cycle T+1+`mem_wait`.
- Throughput: one response per `mem_wait`+1 cycles when `mem_valid` is held continuously.
- `mem_ready` and `mem_rdata` come directly from flops. There is no combinational input-to-output path.

## Configuration
- `MEM_RANGE_CHECK_EN` defined:
  - Affects addresses below `mem_base_addr` or at/above `mem_base_addr` + 4·2^`mem_depth`.
  - Such an access gets the normal latency, `mem_ready`=1 and `mem_rdata`=0.
  - Writes to such addresses are suppressed.
- Not defined: no check. The word index wraps modulo 2^`mem_depth`.

## Structure
- Package `mem_responder_wires` holds:
  - the state encoding constants: IDLE=0, WAIT=1, RESP=2;
  - `mem_responder_ram_in_type`, with fields `wen[3:0]`, `addr`, `wdata`;
  - `mem_responder_ram_out_type`, with field `rdata`.
- Sub-module `mem_responder_ram` contains the word array. It has a byte-enabled write and a registered read, and is addressed by `mem_depth`.
- The top level contains the FSM, the counter, the latched request and the range check.

## Test plan
- Read latency: `mem_wait`=2, word at base+0x10 preloaded with 0xDEADBEEF, read requested at edge T -> `mem_ready` high only in cycle T+3, with `mem_rdata`=0xDEADBEEF.
- Byte-strobe write: word 0x11223344, write 0xAABBCCDD with `mem_wstrb`=4'b0101, then a read -> write response has `mem_rdata`=0; read returns 0x11BB33DD.
- Burst: `mem_wait`=0, `mem_valid` held high, address stepped +4 on each `mem_ready` from base over 4 words -> 4 consecutive `mem_ready` cycles returning the preloaded words in order.
- Fence: `mem_wait`=1, fence request -> `mem_ready` after 2 cycles, `mem_rdata`=0, array unchanged on readback.
- Reset mid-operation: `mem_wait`=3, write issued, `rst` asserted for 1 cycle during WAIT -> no `mem_ready`, outputs return to 0, target word unchanged.
- Out of range (`mem_depth`=4, base 0x1000, address 0x1040):
  - with `MEM_RANGE_CHECK_EN` -> `mem_rdata`=0, and a write is dropped;
  - without it -> the access aliases to word 0.
